// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: forwards rs/rt, decodes the ALU controls and builds the
// immediate, then holds the result in a one-entry valid/ready stage with stall and flush.
module id_ex_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        exm_wr_en,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_wr_en,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_result,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  S,
  output logic        sign1,
  output logic        sign2,
  output logic [4:0]  rd,
  output logic        reg_wr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        branch,
  output logic [31:0] store_data,
  output logic        illegal
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic [5:0]      opcode, funct;
  logic [RW-1:0]   rs_idx, rt_idx;
  logic [XLEN-1:0] fwd_rs, fwd_rt, sext_imm, zext_imm;
  logic [XLEN-1:0] n_a, n_b;
  logic [2:0]      n_s;
  logic            n_sign1, n_sign2, n_reg_wr, n_mem_rd, n_mem_wr, n_branch, n_illegal;
  logic [RW-1:0]   n_rd;
  logic            capture;

  assign opcode   = instr[31:26];
  assign rs_idx   = instr[25:21];
  assign rt_idx   = instr[20:16];
  assign funct    = instr[5:0];
  assign sext_imm = {{16{instr[15]}}, instr[15:0]};
  assign zext_imm = {16'h0000, instr[15:0]};

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // EX/MEM takes precedence over MEM/WB; register 0 always reads the register file.
  always_comb begin
    fwd_rs = rs_data;
    fwd_rt = rt_data;
    if (mwb_wr_en && mwb_rd == rs_idx && rs_idx != '0) fwd_rs = mwb_result;
    if (exm_wr_en && exm_rd == rs_idx && rs_idx != '0) fwd_rs = exm_result;
    if (mwb_wr_en && mwb_rd == rt_idx && rt_idx != '0) fwd_rt = mwb_result;
    if (exm_wr_en && exm_rd == rt_idx && rt_idx != '0) fwd_rt = exm_result;
  end

  always_comb begin
    n_a       = '0;
    n_b       = '0;
    n_s       = 3'b000;
    n_sign1   = 1'b0;
    n_sign2   = 1'b0;
    n_rd      = '0;
    n_reg_wr  = 1'b0;
    n_mem_rd  = 1'b0;
    n_mem_wr  = 1'b0;
    n_branch  = 1'b0;
    n_illegal = 1'b0;
    if (opcode == 6'h00) begin
      n_a      = fwd_rs;
      n_b      = fwd_rt;
      n_rd     = instr[15:11];
      n_reg_wr = 1'b1;
      case (funct)
        6'h20: begin n_s = 3'b000; n_sign1 = 1'b1; n_sign2 = 1'b1; end
        6'h21: n_s = 3'b000;
        6'h22: begin n_s = 3'b001; n_sign1 = 1'b1; n_sign2 = 1'b1; end
        6'h23: n_s = 3'b001;
        6'h24: n_s = 3'b010;
        6'h25: n_s = 3'b011;
        6'h26: n_s = 3'b100;
        6'h2A: begin n_s = 3'b101; n_sign1 = 1'b1; n_sign2 = 1'b1; end
        6'h00: begin n_s = 3'b110; n_a = fwd_rt; n_b = XLEN'(instr[10:6]); end
        6'h02: begin n_s = 3'b111; n_a = fwd_rt; n_b = XLEN'(instr[10:6]); end
        default: begin
          n_a       = '0;
          n_b       = '0;
          n_rd      = '0;
          n_reg_wr  = 1'b0;
          n_illegal = 1'b1;
        end
      endcase
    end else begin
      n_a  = fwd_rs;
      n_rd = rt_idx;
      case (opcode)
        6'h08: begin n_b = sext_imm; n_sign1 = 1'b1; n_sign2 = 1'b1; n_reg_wr = 1'b1; end
        6'h0C: begin n_s = 3'b010; n_b = zext_imm; n_reg_wr = 1'b1; end
        6'h0D: begin n_s = 3'b011; n_b = zext_imm; n_reg_wr = 1'b1; end
        6'h0A: begin
          n_s = 3'b101; n_b = sext_imm; n_sign1 = 1'b1; n_sign2 = 1'b1; n_reg_wr = 1'b1;
        end
        6'h23: begin n_b = sext_imm; n_mem_rd = 1'b1; n_reg_wr = 1'b1; end
        6'h2B: begin n_b = sext_imm; n_mem_wr = 1'b1; end
        6'h04: begin n_s = 3'b001; n_b = fwd_rt; n_branch = 1'b1; end
        default: begin
          n_a       = '0;
          n_rd      = '0;
          n_illegal = 1'b1;
        end
      endcase
    end
  end

  // Flush beats capture; payload only moves on capture, so a drain or stall holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      a          <= '0;
      b          <= '0;
      S          <= 3'b000;
      sign1      <= 1'b0;
      sign2      <= 1'b0;
      rd         <= '0;
      reg_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      branch     <= 1'b0;
      store_data <= '0;
      illegal    <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (capture)   out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (capture) begin
        a          <= n_a;
        b          <= n_b;
        S          <= n_s;
        sign1      <= n_sign1;
        sign2      <= n_sign2;
        rd         <= n_rd;
        reg_wr     <= n_reg_wr;
        mem_rd     <= n_mem_rd;
        mem_wr     <= n_mem_wr;
        branch     <= n_branch;
        store_data <= fwd_rt;
        illegal    <= n_illegal;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed-vector bench for id_ex_operand_stage with hand-computed expectations.
module tb_id_ex_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready;
  logic [31:0] instr, rs_data, rt_data;
  logic        exm_wr_en, mwb_wr_en;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        flush, out_valid, out_ready;
  logic [31:0] a, b, store_data;
  logic [2:0]  S;
  logic        sign1, sign2, reg_wr, mem_rd, mem_wr, branch, illegal;
  logic [4:0]  rd;

  int n_vec = 0;
  int n_err = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .exm_wr_en(exm_wr_en), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd),
    .mwb_result(mwb_result), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .S(S), .sign1(sign1), .sign2(sign2), .rd(rd), .reg_wr(reg_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .store_data(store_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rdi, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rdi, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    exm_wr_en = 1'b0; exm_rd = '0; exm_result = '0;
    mwb_wr_en = 1'b0; mwb_rd = '0; mwb_result = '0;
    flush = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_a", a, 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #9 rst_n = 1'b1;

    // add $3,$1,$2
    in_valid = 1'b1; instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    rs_data = 32'd4; rt_data = 32'd8;
    step();
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_a", a, 32'd4);
    check("add_b", b, 32'd8);
    check("add_S", 32'(S), 32'd0);
    check("add_signs", {30'd0, sign1, sign2}, 32'd3);
    check("add_rd", 32'(rd), 32'd3);
    check("add_reg_wr", 32'(reg_wr), 32'd1);
    check("add_illegal", 32'(illegal), 32'd0);

    // addi $5,$1,-5 with rs=-7
    instr = i_ins(6'h08, 5'd1, 5'd5, 16'hFFFB); rs_data = 32'hFFFF_FFF9;
    step();
    check("addi_a", a, 32'hFFFF_FFF9);
    check("addi_b", b, 32'hFFFF_FFFB);
    check("addi_S", 32'(S), 32'd0);
    check("addi_rd", 32'(rd), 32'd5);
    check("addi_sign1", 32'(sign1), 32'd1);

    // andi $6,$1,0xFFFF
    instr = i_ins(6'h0C, 5'd1, 5'd6, 16'hFFFF);
    step();
    check("andi_b", b, 32'h0000_FFFF);
    check("andi_S", 32'(S), 32'd2);
    check("andi_sign1", 32'(sign1), 32'd0);

    // sll $7,$2,5 with rt=8
    instr = r_ins(5'd0, 5'd2, 5'd7, 5'd5, 6'h00); rt_data = 32'd8;
    step();
    check("sll_a", a, 32'd8);
    check("sll_b", b, 32'd5);
    check("sll_S", 32'(S), 32'd6);

    // forwarding on rs=$1
    instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20); rs_data = 32'h11;
    exm_wr_en = 1'b1; exm_rd = 5'd1; exm_result = 32'hAA;
    mwb_wr_en = 1'b1; mwb_rd = 5'd1; mwb_result = 32'hBB;
    step();
    check("fwd_exm_a", a, 32'hAA);
    check("fwd_exm_b", b, 32'd8);
    exm_wr_en = 1'b0;
    step();
    check("fwd_mwb_a", a, 32'hBB);
    instr = r_ins(5'd0, 5'd2, 5'd3, 5'd0, 6'h20);
    exm_wr_en = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
    step();
    check("fwd_r0_a", a, 32'h11);

    // sw $2,4($1) with rt forwarded from MEM/WB
    exm_wr_en = 1'b0;
    instr = i_ins(6'h2B, 5'd1, 5'd2, 16'h0004); rs_data = 32'h100;
    mwb_rd = 5'd2; mwb_result = 32'hCC;
    step();
    check("sw_store_data", store_data, 32'hCC);
    check("sw_b", b, 32'd4);
    check("sw_mem_wr", 32'(mem_wr), 32'd1);
    check("sw_reg_wr", 32'(reg_wr), 32'd0);
    mwb_wr_en = 1'b0;

    // stall for three cycles with a new instruction waiting
    out_ready = 1'b0;
    instr = r_ins(5'd1, 5'd2, 5'd9, 5'd0, 6'h22); rs_data = 32'd20; rt_data = 32'd3;
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_a", a, 32'h100);
      check("stall_mem_wr", 32'(mem_wr), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("sub_a", a, 32'd20);
    check("sub_S", 32'(S), 32'd1);
    check("sub_rd", 32'(rd), 32'd9);
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold_a", a, 32'd20);

    // flush while holding an entry, with a competing capture
    in_valid = 1'b1; out_ready = 1'b0;
    instr = r_ins(5'd1, 5'd2, 5'd10, 5'd0, 6'h25); rs_data = 32'hF0; rt_data = 32'h0F;
    step();
    check("or_S", 32'(S), 32'd3);
    out_ready = 1'b1; flush = 1'b1;
    instr = r_ins(5'd1, 5'd2, 5'd11, 5'd0, 6'h26); rs_data = 32'h55;
    step();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_no_cap_S", 32'(S), 32'd3);
    check("flush_no_cap_a", a, 32'hF0);
    flush = 1'b0;

    // illegal opcode and funct
    instr = i_ins(6'h3F, 5'd1, 5'd2, 16'h1234);
    step();
    check("ill_op_valid", 32'(out_valid), 32'd1);
    check("ill_op_illegal", 32'(illegal), 32'd1);
    check("ill_op_reg_wr", 32'(reg_wr), 32'd0);
    check("ill_op_S", 32'(S), 32'd0);
    check("ill_op_a", a, 32'd0);
    instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F);
    step();
    check("ill_fn_illegal", 32'(illegal), 32'd1);
    check("ill_fn_b", b, 32'd0);

    // beq and lw
    instr = i_ins(6'h04, 5'd1, 5'd2, 16'h0010); rs_data = 32'd5; rt_data = 32'd6;
    step();
    check("beq_branch", 32'(branch), 32'd1);
    check("beq_b", b, 32'd6);
    check("beq_S", 32'(S), 32'd1);
    check("beq_reg_wr", 32'(reg_wr), 32'd0);
    instr = i_ins(6'h23, 5'd1, 5'd4, 16'h8000);
    step();
    check("lw_b", b, 32'hFFFF_8000);
    check("lw_mem_rd", 32'(mem_rd), 32'd1);
    check("lw_reg_wr", 32'(reg_wr), 32'd1);
    check("lw_rd", 32'(rd), 32'd4);

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_a", a, 32'd0);
    check("arst_b", b, 32'd0);
    check("arst_mem_rd", 32'(mem_rd), 32'd0);
    check("arst_rd", 32'(rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
